// File: rtl/sdram_arbiter.sv
// SDRAM arbiter: ROM download buffer, CPU port and cassette read port
// sharing one SDRAM controller, with a CPU-starvation guard for cassette.
module sdram_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int ACC_CYCLES = 4,
  parameter int CAS_STARVE = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_ovf,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  input  logic              cas_req,
  input  logic [ADDR_W-1:0] cas_addr,
  output logic [7:0]        cas_dout,
  output logic              cas_ack,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_din,
  output logic              sd_we,
  output logic              sd_rd,
  input  logic [7:0]        sd_dout,
  input  logic              sd_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OWN_DL, OWN_CPU, OWN_CAS} own_t;

  localparam int SW = $clog2(CAS_STARVE + 1);
  localparam logic [3:0]    LAST = 4'(ACC_CYCLES - 1);
  localparam logic [SW-1:0] SMAX = SW'(CAS_STARVE);

  state_t            state_q, state_d;
  own_t              own_q, own_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              dlv_q, dlv_d;
  logic [ADDR_W-1:0] dla_q, dla_d;
  logic [7:0]        dld_q, dld_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [7:0]        sd_din_q, sd_din_d;
  logic              sd_we_q, sd_we_d;
  logic              sd_rd_q, sd_rd_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic [7:0]        cas_dout_q, cas_dout_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cas_ack_q, cas_ack_d;

  logic g_dl, g_cas_s, g_cpu, g_cas, dl_done;

  // Grant selection: download, starved cassette, cpu, cassette
  always_comb begin
    g_dl    = dlv_q;
    g_cas_s = !dlv_q && cas_req && (starve_q == SMAX);
    g_cpu   = !dlv_q && !g_cas_s && cpu_req;
    g_cas   = g_cas_s || (!dlv_q && !cpu_req && cas_req);
  end

  // Next-state logic for FSM, buffer, counters and registered outputs
  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    dlv_d      = dlv_q;
    dla_d      = dla_q;
    dld_d      = dld_q;
    ovf_d      = ovf_q;
    sd_addr_d  = sd_addr_q;
    sd_din_d   = sd_din_q;
    sd_we_d    = sd_we_q;
    sd_rd_d    = sd_rd_q;
    cpu_dout_d = cpu_dout_q;
    cas_dout_d = cas_dout_q;
    cpu_ack_d  = 1'b0;
    cas_ack_d  = 1'b0;
    dl_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sd_ready) begin
          unique case (1'b1)
            g_dl: begin
              own_d     = OWN_DL;
              sd_addr_d = dla_q;
              sd_din_d  = dld_q;
              sd_we_d   = 1'b1;
              sd_rd_d   = 1'b0;
              cnt_d     = '0;
              state_d   = ACCESS;
            end
            g_cpu: begin
              own_d     = OWN_CPU;
              sd_addr_d = cpu_addr;
              sd_din_d  = cpu_din;
              sd_we_d   = cpu_we;
              sd_rd_d   = !cpu_we;
              cnt_d     = '0;
              state_d   = ACCESS;
              if (cas_req && starve_q != SMAX)
                starve_d = starve_q + 1'b1;
            end
            g_cas: begin
              own_d     = OWN_CAS;
              sd_addr_d = cas_addr;
              sd_din_d  = '0;
              sd_we_d   = 1'b0;
              sd_rd_d   = 1'b1;
              cnt_d     = '0;
              starve_d  = '0;
              state_d   = ACCESS;
            end
            default: ;
          endcase
        end
      end
      ACCESS: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          sd_we_d = 1'b0;
          sd_rd_d = 1'b0;
          unique case (own_q)
            OWN_CPU: begin
              cpu_ack_d = 1'b1;
              if (sd_rd_q)
                cpu_dout_d = sd_dout;
            end
            OWN_CAS: begin
              cas_ack_d  = 1'b1;
              cas_dout_d = sd_dout;
            end
            default: begin
              dlv_d   = 1'b0;
              dl_done = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!cas_req)
      starve_d = '0;
    if (dl_wr) begin
      if (!dlv_q || dl_done) begin
        dlv_d = 1'b1;
        dla_d = dl_addr;
        dld_d = dl_data;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      own_q      <= OWN_DL;
      cnt_q      <= '0;
      starve_q   <= '0;
      dlv_q      <= 1'b0;
      dla_q      <= '0;
      dld_q      <= '0;
      ovf_q      <= 1'b0;
      sd_addr_q  <= '0;
      sd_din_q   <= '0;
      sd_we_q    <= 1'b0;
      sd_rd_q    <= 1'b0;
      cpu_dout_q <= '0;
      cas_dout_q <= '0;
      cpu_ack_q  <= 1'b0;
      cas_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      dlv_q      <= dlv_d;
      dla_q      <= dla_d;
      dld_q      <= dld_d;
      ovf_q      <= ovf_d;
      sd_addr_q  <= sd_addr_d;
      sd_din_q   <= sd_din_d;
      sd_we_q    <= sd_we_d;
      sd_rd_q    <= sd_rd_d;
      cpu_dout_q <= cpu_dout_d;
      cas_dout_q <= cas_dout_d;
      cpu_ack_q  <= cpu_ack_d;
      cas_ack_q  <= cas_ack_d;
    end
  end

  assign dl_ovf   = ovf_q;
  assign cpu_dout = cpu_dout_q;
  assign cpu_ack  = cpu_ack_q;
  assign cas_dout = cas_dout_q;
  assign cas_ack  = cas_ack_q;
  assign sd_addr  = sd_addr_q;
  assign sd_din   = sd_din_q;
  assign sd_we    = sd_we_q;
  assign sd_rd    = sd_rd_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: table of cpu transactions plus
// hand-written sequences for download, starvation, sd_ready and reset.
module tb_sdram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        dl_wr = 1'b0;
  logic [17:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_ovf;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        cas_req = 1'b0;
  logic [17:0] cas_addr = '0;
  logic [7:0]  cas_dout;
  logic        cas_ack;
  logic [17:0] sd_addr;
  logic [7:0]  sd_din;
  logic        sd_we;
  logic        sd_rd;
  logic [7:0]  sd_dout = '0;
  logic        sd_ready = 1'b1;

  int pass_cnt = 0;
  int total = 0;
  int mutex_bad = 0;

  sdram_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_ovf(dl_ovf),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .cas_req(cas_req), .cas_addr(cas_addr),
    .cas_dout(cas_dout), .cas_ack(cas_ack),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_rd(sd_rd),
    .sd_dout(sd_dout), .sd_ready(sd_ready)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys)
    if (sd_we && sd_rd) mutex_bad++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dl_wr = 1'b0; cpu_req = 1'b0; cas_req = 1'b0; sd_ready = 1'b1;
    nxt(); nxt();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [7:0]  din;
    logic [7:0]  sdd;
    logic [7:0]  exp_dout;
    int          exp_rd;
    int          exp_we;
  } vec_t;

  vec_t vt [5];

  initial begin
    int lat, nrd, nwe, c, n, first, ackc;
    logic [17:0] a_seen, la;
    logic [7:0]  d_seen, ld;
    logic [19:0] seq, eseq;
    logic        acked;

    vt[0] = '{1'b0, 18'h01234, 8'h00, 8'h5A, 8'h5A, 4, 0};
    vt[1] = '{1'b1, 18'h3FFFF, 8'hA5, 8'h77, 8'h5A, 0, 4};
    vt[2] = '{1'b0, 18'h00000, 8'h00, 8'hFF, 8'hFF, 4, 0};
    vt[3] = '{1'b1, 18'h20000, 8'h00, 8'h11, 8'hFF, 0, 4};
    vt[4] = '{1'b0, 18'h3FFFF, 8'h3C, 8'h00, 8'h00, 4, 0};

    nxt(); nxt();
    reset = 1'b0;
    @(negedge clk_sys);
    chk("reset_outputs",
        64'({dl_ovf, cpu_ack, cas_ack, sd_we, sd_rd,
             sd_addr, sd_din, cpu_dout, cas_dout}), 64'd0);
    nxt();

    // table of cpu transactions
    for (int i = 0; i < 5; i++) begin
      sd_dout = vt[i].sdd; cpu_we = vt[i].we;
      cpu_addr = vt[i].addr; cpu_din = vt[i].din;
      cpu_req = 1'b1;
      lat = -1; nrd = 0; nwe = 0; a_seen = '0; d_seen = '0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk_sys);
        if (sd_rd) nrd++;
        if (sd_we) nwe++;
        if (k == 1) begin a_seen = sd_addr; d_seen = sd_din; end
        if (cpu_ack) begin lat = k; break; end
      end
      nxt();
      cpu_req = 1'b0;
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd5);
      chk($sformatf("v%0d_rd_cycles", i), 64'(nrd), 64'(vt[i].exp_rd));
      chk($sformatf("v%0d_we_cycles", i), 64'(nwe), 64'(vt[i].exp_we));
      chk($sformatf("v%0d_addr", i), 64'(a_seen), 64'(vt[i].addr));
      chk($sformatf("v%0d_dout", i), 64'(cpu_dout), 64'(vt[i].exp_dout));
      if (vt[i].we)
        chk($sformatf("v%0d_din", i), 64'(d_seen), 64'(vt[i].din));
    end

    // download strobes two cycles apart: second is dropped
    do_reset();
    nwe = 0; la = '0; ld = '0;
    for (c = 0; c < 16; c++) begin
      dl_wr = (c == 0 || c == 2);
      dl_addr = (c == 0) ? 18'h00100 : 18'h00200;
      dl_data = (c == 0) ? 8'h11 : 8'h22;
      @(negedge clk_sys);
      if (sd_we) begin nwe++; la = sd_addr; ld = sd_din; end
      nxt();
    end
    dl_wr = 1'b0;
    chk("ovf2_flag", 64'(dl_ovf), 64'd1);
    chk("ovf2_we_cycles", 64'(nwe), 64'd4);
    chk("ovf2_addr", 64'(la), 64'h100);
    chk("ovf2_data", 64'(ld), 64'h11);

    // download strobes six cycles apart: all written
    do_reset();
    nwe = 0; la = '0; ld = '0;
    for (c = 0; c < 24; c++) begin
      dl_wr = (c % 6 == 0) && (c < 18);
      dl_addr = 18'(18'h300 + c);
      dl_data = 8'(8'h40 + c);
      @(negedge clk_sys);
      if (sd_we) begin nwe++; la = sd_addr; ld = sd_din; end
      nxt();
    end
    dl_wr = 1'b0;
    chk("ovf6_flag", 64'(dl_ovf), 64'd0);
    chk("ovf6_we_cycles", 64'(nwe), 64'd12);
    chk("ovf6_addr", 64'(la), 64'h30C);
    chk("ovf6_data", 64'(ld), 64'h4C);

    // cpu and cassette both held: 8 cpu grants then 1 cassette
    do_reset();
    sd_dout = 8'hC3; cpu_we = 1'b0; cpu_addr = 18'h00010;
    cas_addr = 18'h10000; cpu_req = 1'b1; cas_req = 1'b1;
    n = 0; seq = '0;
    for (c = 0; c < 120; c++) begin
      @(negedge clk_sys);
      if (n < 20 && cpu_ack) begin seq[n] = 1'b0; n++; end
      if (n < 20 && cas_ack) begin seq[n] = 1'b1; n++; end
      nxt();
    end
    cpu_req = 1'b0; cas_req = 1'b0;
    eseq = 20'b0;
    eseq[8] = 1'b1;
    eseq[17] = 1'b1;
    chk("starve_ack_count", 64'(n), 64'd20);
    chk("starve_pattern", 64'(seq), 64'(eseq));
    chk("cas_dout", 64'(cas_dout), 64'hC3);

    // download pending then cpu request: download goes first
    do_reset();
    cpu_we = 1'b0; cpu_addr = 18'h00020;
    dl_addr = 18'h00ABC; dl_data = 8'h5C;
    first = -1; ackc = -1; acked = 1'b0;
    for (c = 0; c < 20; c++) begin
      dl_wr = (c == 0);
      cpu_req = (c >= 1) && !acked;
      @(negedge clk_sys);
      if (sd_we && first < 0) first = c;
      if (cpu_ack) begin ackc = c; acked = 1'b1; end
      nxt();
    end
    cpu_req = 1'b0; dl_wr = 1'b0;
    chk("dlcpu_first_we", 64'(first), 64'd2);
    chk("dlcpu_cpu_ack", 64'(ackc), 64'd12);

    // sd_ready low blocks all grants
    do_reset();
    sd_ready = 1'b0;
    dl_addr = 18'h0AAAA; dl_data = 8'h66;
    cpu_addr = 18'h00030; cas_addr = 18'h00040;
    nrd = 0; first = -1; la = '0;
    for (c = 0; c < 14; c++) begin
      dl_wr = (c == 0);
      cpu_req = 1'b1; cas_req = 1'b1;
      sd_ready = (c >= 10);
      @(negedge clk_sys);
      if (c < 10 && (sd_we || sd_rd)) nrd++;
      if (first < 0 && (sd_we || sd_rd)) begin
        first = c; la = sd_addr; nwe = int'(sd_we);
      end
      nxt();
    end
    dl_wr = 1'b0; cpu_req = 1'b0; cas_req = 1'b0;
    for (c = 0; c < 12; c++) nxt();
    chk("notready_quiet", 64'(nrd), 64'd0);
    chk("ready_first_cycle", 64'(first), 64'd11);
    chk("ready_first_is_dl", 64'(nwe), 64'd1);
    chk("ready_first_addr", 64'(la), 64'h0AAAA);

    // reset on the second access cycle aborts the read
    do_reset();
    sd_dout = 8'h99; cpu_we = 1'b0; cpu_addr = 18'h00155;
    cpu_req = 1'b1;
    @(negedge clk_sys); nxt();
    @(negedge clk_sys); nxt();
    reset = 1'b1;
    @(negedge clk_sys);
    chk("abort_rd_before", 64'(sd_rd), 64'd1);
    nxt();
    reset = 1'b0; cpu_req = 1'b0;
    @(negedge clk_sys);
    chk("abort_outputs",
        64'({dl_ovf, cpu_ack, cas_ack, sd_we, sd_rd,
             sd_addr, sd_din, cpu_dout, cas_dout}), 64'd0);
    n = 0;
    for (c = 0; c < 10; c++) begin
      nxt();
      @(negedge clk_sys);
      if (cpu_ack || sd_rd) n++;
    end
    chk("abort_no_ack", 64'(n), 64'd0);

    chk("we_rd_exclusive", 64'(mutex_bad), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
